// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared types, default sizes and the power-on demo program
// for the field-loadable program memory.
//   state_e       : controller states (INIT / RUN / LOAD)
//   NOP_DEFAULT   : default word driven while the memory is not serving fetches
//   default_word  : returns the built-in program word for an index
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam int         ADDR_W_DEFAULT   = 4;
    localparam int         DATA_W_DEFAULT   = 8;
    localparam int         DEFAULT_PROG_LEN = 16;
    localparam logic [7:0] NOP_DEFAULT      = 8'h00;

    // Power-on demo program; indices past its end read as NOP so larger
    // memories come up with a harmless tail.
    function automatic logic [7:0] default_word(input logic [31:0] idx);
        case (idx)
            32'd0:   default_word = 8'hB7;
            32'd1:   default_word = 8'h01;
            32'd2:   default_word = 8'hE1;
            32'd3:   default_word = 8'h01;
            32'd4:   default_word = 8'hE3;
            32'd5:   default_word = 8'hB6;
            32'd6:   default_word = 8'h01;
            32'd7:   default_word = 8'hE6;
            32'd8:   default_word = 8'h01;
            32'd9:   default_word = 8'hE8;
            32'd10:  default_word = 8'hB0;
            32'd11:  default_word = 8'hB4;
            32'd12:  default_word = 8'h01;
            32'd13:  default_word = 8'hEA;
            32'd14:  default_word = 8'hB8;
            32'd15:  default_word = 8'hF0;
            default: default_word = NOP_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// prog_mem_if: CPU fetch port plus loader valid/ready port of prog_mem.
//   addr/data/ready                 : fetch address, registered data, data-valid
//   ld_start/ld_base/ld_len         : load request, first address, word count
//   ld_valid/ld_data/ld_ready       : word handshake
//   ld_done/ld_err                  : completion / illegal-length pulses
// master = CPU + loader side, slave = memory side.
interface prog_mem_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;

    modport master (
        output addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
        input  data, ready, ld_ready, ld_done, ld_err
    );

    modport slave (
        input  addr, ld_start, ld_base, ld_len, ld_valid, ld_data,
        output data, ready, ld_ready, ld_done, ld_err
    );
endinterface

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: DEPTH x DATA_W synchronous array with one write port and
// one registered read port. Contents are not reset; the controller rewrites
// them after every reset.
//   clk   : rising-edge clock
//   we    : write enable, waddr/wdata : write address/data
//   raddr : read address, rdata : read data registered on the edge
module prog_mem_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Array write and registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/prog_mem.sv
// prog_mem: field-loadable program memory for the CPU fetch path.
// After reset it copies the default program into the array (INIT), then
// serves 1-cycle-latency fetches (RUN). A loader can replace a segment over
// a valid/ready port (LOAD); fetches stall (ready=0, data=NOP) meanwhile.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : prog_mem_if slave modport (fetch + loader signals)
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    prog_mem_if.slave    bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;
    logic [ADDR_W:0]   rem_r;
    logic [ADDR_W:0]   rem_nxt_s;
    logic              ready_r;
    logic              ready_nxt_s;
    logic              ld_ready_r;
    logic              ld_done_r;
    logic              ld_done_nxt_s;
    logic              ld_err_r;
    logic              ld_err_nxt_s;

    logic              we_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] init_word_s;
    logic [DATA_W-1:0] rdata_s;
    logic              len_ok_s;
    logic              xfer_s;

    assign init_word_s = DATA_W'(default_word(32'(ptr_r)));
    assign len_ok_s    = (bus.ld_len != LEN_ZERO) && (bus.ld_len <= LEN_MAX);
    assign xfer_s      = bus.ld_valid && (state_r == ST_LOAD);

    prog_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (ptr_r),
        .wdata (wdata_s),
        .raddr (bus.addr),
        .rdata (rdata_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (ptr_r == PTR_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (bus.ld_start && len_ok_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (xfer_s && (rem_r == REM_ONE)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Per-state write strobes, pointer/count updates and pulse requests.
    always_comb begin
        we_s          = 1'b0;
        wdata_s       = bus.ld_data;
        ptr_nxt_s     = ptr_r;
        rem_nxt_s     = rem_r;
        ld_done_nxt_s = 1'b0;
        ld_err_nxt_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                // ptr wraps DEPTH-1 -> 0 by width, leaving it at 0 for RUN.
                we_s      = 1'b1;
                wdata_s   = init_word_s;
                ptr_nxt_s = ptr_r + PTR_ONE;
            end
            ST_RUN: begin
                if (bus.ld_start) begin
                    if (len_ok_s) begin
                        ptr_nxt_s = bus.ld_base;
                        rem_nxt_s = bus.ld_len;
                    end else begin
                        ld_err_nxt_s = 1'b1;
                    end
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    we_s          = 1'b1;
                    ptr_nxt_s     = ptr_r + PTR_ONE;
                    rem_nxt_s     = rem_r - REM_ONE;
                    ld_done_nxt_s = (rem_r == REM_ONE);
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                we_s      = 1'b0;
                ptr_nxt_s = PTR_ZERO;
            end
        endcase
        // READY needs a RUN-state read on this edge and must drop in the
        // same cycle a load is accepted.
        ready_nxt_s = (state_r == ST_RUN) && (state_nxt_s == ST_RUN);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r      <= PTR_ZERO;
            rem_r      <= LEN_ZERO;
            ready_r    <= 1'b0;
            ld_ready_r <= 1'b0;
            ld_done_r  <= 1'b0;
            ld_err_r   <= 1'b0;
        end else begin
            ptr_r      <= ptr_nxt_s;
            rem_r      <= rem_nxt_s;
            ready_r    <= ready_nxt_s;
            ld_ready_r <= (state_nxt_s == ST_LOAD);
            ld_done_r  <= ld_done_nxt_s;
            ld_err_r   <= ld_err_nxt_s;
        end
    end

    // The RAM read register and ready_r update on the same edge, so
    // masking with ready_r keeps DATA and READY aligned.
    assign bus.data     = ready_r ? rdata_s : NOP_WORD;
    assign bus.ready    = ready_r;
    assign bus.ld_ready = ld_ready_r;
    assign bus.ld_done  = ld_done_r;
    assign bus.ld_err   = ld_err_r;
endmodule
